// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared mips32 opcodes, instruction types, fetch defaults and FSM encoding
package mips32_pkg;

    // Instruction memory geometry and fetch defaults
    localparam int          IMEM_AW          = 10;
    localparam int          FETCH_DEPTH      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

    // Opcodes (ir[31:26])
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // Instruction type encodings used by later pipeline stages
    localparam logic [2:0] TYPE_RR_ALU = 3'b000;
    localparam logic [2:0] TYPE_RM_ALU = 3'b001;
    localparam logic [2:0] TYPE_LOAD   = 3'b010;
    localparam logic [2:0] TYPE_STORE  = 3'b011;
    localparam logic [2:0] TYPE_BRANCH = 3'b100;
    localparam logic [2:0] TYPE_HALT   = 3'b101;

    // Fetch FSM: IDLE = nothing outstanding, WAIT = keep the return, DROP = discard the return
    localparam logic [1:0] FS_IDLE = 2'd0;
    localparam logic [1:0] FS_WAIT = 2'd1;
    localparam logic [1:0] FS_DROP = 2'd2;

    // One prefetch queue entry
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } fetch_entry_t;

    function automatic logic [2:0] instr_type(input logic [5:0] op);
        logic [2:0] t;
        t = TYPE_HALT;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = TYPE_RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     t = TYPE_RM_ALU;
            OP_LW:                                         t = TYPE_LOAD;
            OP_SW:                                         t = TYPE_STORE;
            OP_BNEQZ, OP_BEQZ:                             t = TYPE_BRANCH;
            default:                                       t = TYPE_HALT;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips32_fetch_fifo.sv
// rtl/mips32_fetch_fifo.sv - DEPTH-entry prefetch queue of {ir, npc} with flush
module mips32_fetch_fifo
    import mips32_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk1,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Pop on empty is a no-op; a push at full is only taken alongside a pop
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    // Head is read straight from the storage flops so it holds still until popped
    assign head = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue outright
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero out of reset
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/mips32_fetch_unit.sv
// rtl/mips32_fetch_unit.sv - mips32 instruction fetch: PC, imem request FSM, prefetch queue to ID
module mips32_fetch_unit
    import mips32_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH,
    parameter int          AW       = IMEM_AW,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          halt,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_ir,
    output logic [31:0]   id_npc,
    output logic          halted
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   inflight_npc;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] count;
    logic [CW:0]   occ_next;
    logic          redir;
    logic          rsp_keep;
    logic          push;
    logic          pop;
    logic          issue;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

    // Halt wins over a same-cycle redirect, and a halted unit ignores redirects
    assign redir    = redirect_valid && !halt && !halted;
    assign rsp_keep = (state == FS_WAIT) && imem_rvalid;
    assign push     = rsp_keep && !redir;
    assign pop      = id_valid && id_ready && !redir;
    assign occ_next = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

    // A new request may go out when the single slot is free (or freeing now) and the queue has room
    assign issue = !halted && !halt && !redirect_valid
                && ((state == FS_IDLE) || rsp_keep)
                && (occ_next < DEPTH_W);

    assign imem_req  = issue && rst_n;
    assign imem_addr = pc[AW-1:0];

    assign push_data.ir  = imem_rdata;
    assign push_data.npc = inflight_npc;

    assign id_valid = (count != '0);
    assign id_ir    = head.ir;
    assign id_npc   = head.npc;

    mips32_fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redir),
        .head      (head),
        .count     (count)
    );

    // Next FSM state: redirect turns an outstanding read into one to be dropped
    always_comb begin
        state_nxt = state;
        if (state != FS_IDLE && state != FS_WAIT && state != FS_DROP) begin
            state_nxt = FS_IDLE;
        end else if (redir) begin
            if (state == FS_WAIT)
                state_nxt = imem_rvalid ? FS_IDLE : FS_DROP;
            else if (state == FS_DROP && imem_rvalid)
                state_nxt = FS_IDLE;
        end else if (issue) begin
            state_nxt = FS_WAIT;
        end else if (imem_rvalid && state != FS_IDLE) begin
            state_nxt = FS_IDLE;
        end
    end

    // PC, in-flight NPC, FSM state and the sticky halt flag
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            inflight_npc <= '0;
            state        <= FS_IDLE;
            halted       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (halt) halted <= 1'b1;
            if (redir) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc           <= pc + 32'd1;
                inflight_npc <= pc + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// tb/tb_mips32_fetch_unit.sv - directed self-checking bench for mips32_fetch_unit
module tb_mips32_fetch_unit;

    localparam int AW = 10;

    logic          clk1;
    logic          rst_n;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          halt;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_ir;
    logic [31:0]   id_npc;
    logic          halted;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:1023];
    int mem_lat = 1;
    int cyc     = 0;
    int due_q[$];
    int addr_q[$];

    mips32_fetch_unit #(
        .DEPTH    (4),
        .AW       (AW),
        .RESET_PC (32'h0)
    ) dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ir          (id_ir),
        .id_npc         (id_npc),
        .halted         (halted)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    // Instruction memory with mem_lat cycles of latency, in order
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk1);
            if (imem_req === 1'b1) begin
                due_q.push_back(cyc + mem_lat);
                addr_q.push_back(int'(imem_addr));
            end
            @(posedge clk1);
            #1;
            cyc++;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem[addr_q[0]];
                void'(due_q.pop_front());
                void'(addr_q.pop_front());
            end else begin
                imem_rvalid = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk1);
        #1;
    endtask

    task automatic mid();
        @(negedge clk1);
    endtask

    // Hold reset for n cycles; returns #1 into the first cycle out of reset
    task automatic do_reset(input int n);
        next_cycle();
        rst_n = 1'b0;
        repeat (n) next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input int addr, input int budget, output int waited);
        waited = 0;
        while (!(imem_req === 1'b1 && int'(imem_addr) == addr) && waited < budget) begin
            next_cycle();
            mid();
            waited++;
        end
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (id_valid !== 1'b1 && waited < budget) begin
            next_cycle();
            mid();
            waited++;
        end
    endtask

    logic [31:0] prog [4];
    int w;
    int req_seen;
    int pops;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        prog[0] = 32'h2801000a;
        prog[1] = 32'h28020014;
        prog[2] = 32'h28030019;
        prog[3] = 32'h0ce77800;
        for (int i = 0; i < 4; i++) mem[i] = prog[i];

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        id_ready       = 1'b1;

        // Reset values
        mid();
        chk("rst_id_valid", id_valid, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_id_ir", id_ir, 0);
        chk("rst_id_npc", id_npc, 0);
        chk("rst_halted", halted, 0);

        // Streaming with 1-cycle memory
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        mid();
        chk("a_first_req", imem_req, 1);
        chk("a_first_addr", imem_addr, 0);
        next_cycle(); mid();
        chk("a_c1_valid", id_valid, 0);
        chk("a_c1_addr", imem_addr, 1);
        for (int k = 0; k < 4; k++) begin
            next_cycle(); mid();
            chk("a_valid", id_valid, 1);
            chk("a_ir", id_ir, prog[k]);
            chk("a_npc", id_npc, k + 1);
            chk("a_req", imem_req, 1);
        end

        // Back-pressure: queue fills to DEPTH then fetch stalls
        id_ready = 1'b0;
        do_reset(3);
        req_seen = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) begin
                next_cycle(); mid();
            end else begin
                mid();
            end
            if (imem_req === 1'b1) req_seen++;
            if (c >= 2) chk("b_head_stable", id_ir, prog[0]);
        end
        chk("b_req_count", req_seen, 4);
        chk("b_req_idle", imem_req, 0);
        chk("b_valid", id_valid, 1);
        chk("b_npc", id_npc, 1);
        chk("b_pc", imem_addr, 4);
        next_cycle();
        id_ready = 1'b1;
        mid();
        chk("b_resume_req", imem_req, 1);
        chk("b_resume_addr", imem_addr, 4);
        chk("b_pop1_npc", id_npc, 1);
        for (int k = 2; k <= 5; k++) begin
            next_cycle(); mid();
            chk("b_drain_valid", id_valid, 1);
            chk("b_drain_npc", id_npc, k);
            if (k == 4) chk("b_ir4", id_ir, prog[3]);
            if (k == 5) chk("b_ir5", id_ir, 32'hA000_0004);
        end

        // Redirect coincident with a response and a pop
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'd100;
        mid();
        chk("c_rsp_present", imem_rvalid, 1);
        chk("c_no_req", imem_req, 0);
        next_cycle();
        redirect_valid = 1'b0;
        mid();
        chk("c_flushed", id_valid, 0);
        chk("c_target_req", imem_req, 1);
        chk("c_target_addr", imem_addr, 100);
        next_cycle(); mid();
        chk("c_still_empty", id_valid, 0);
        next_cycle(); mid();
        chk("c_valid", id_valid, 1);
        chk("c_npc", id_npc, 101);
        chk("c_ir", id_ir, 32'hA000_0064);

        // 3-cycle memory, redirect while WAIT on address 2
        mem_lat = 3;
        do_reset(4);
        mid();
        wait_req(2, 20, w);
        chk("d_req2_cycle", w, 6);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'd20;
        mid();
        chk("d_no_req", imem_req, 0);
        chk("d_pre_valid", id_valid, 1);
        next_cycle();
        redirect_valid = 1'b0;
        mid();
        chk("d_flushed", id_valid, 0);
        wait_req(20, 10, w);
        chk("d_target_delay", w, 2);
        chk("d_target_req", imem_req, 1);
        chk("d_stale_dropped", id_valid, 0);
        wait_valid(10, w);
        chk("d_valid_delay", w, 4);
        chk("d_npc", id_npc, 21);
        chk("d_ir", id_ir, 32'hA000_0014);

        // Halt with one in flight and two queued
        id_ready = 1'b0;
        do_reset(4);
        mid();
        chk("e_halted_cleared", halted, 0);
        wait_req(2, 20, w);
        chk("e_req2_cycle", w, 6);
        next_cycle();
        halt = 1'b1;
        mid();
        chk("e_halt_no_req", imem_req, 0);
        next_cycle();
        halt = 1'b0;
        mid();
        chk("e_halted", halted, 1);
        req_seen = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle(); mid();
            if (imem_req === 1'b1) req_seen++;
        end
        chk("e_no_req", req_seen, 0);
        next_cycle();
        id_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 6; c++) begin
            mid();
            if (id_valid === 1'b1) begin
                chk("e_pop_npc", id_npc, pops + 1);
                pops++;
            end
            next_cycle();
        end
        chk("e_pops", pops, 3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd50;
        mid();
        chk("e_redir_no_req", imem_req, 0);
        next_cycle();
        redirect_valid = 1'b0;
        req_seen = 0;
        for (int c = 0; c < 3; c++) begin
            mid();
            if (imem_req === 1'b1) req_seen++;
            if (c < 2) next_cycle();
        end
        chk("e_redir_ignored_req", req_seen, 0);
        chk("e_redir_ignored_pc", imem_addr, 3);
        chk("e_still_halted", halted, 1);
        chk("e_empty", id_valid, 0);

        // Reset mid-stream with a read outstanding
        do_reset(4);
        mid();
        chk("f_halted_cleared", halted, 0);
        wait_req(1, 20, w);
        chk("f_req1_cycle", w, 3);
        next_cycle();
        rst_n = 1'b0;
        mid();
        chk("f_rst_valid", id_valid, 0);
        chk("f_rst_req", imem_req, 0);
        chk("f_rst_pc", imem_addr, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        mid();
        chk("f_late_rsp", imem_rvalid, 1);
        chk("f_restart_req", imem_req, 1);
        chk("f_restart_addr", imem_addr, 0);
        next_cycle(); mid();
        chk("f_late_ignored", id_valid, 0);
        wait_valid(10, w);
        chk("f_valid_delay", w, 3);
        chk("f_npc", id_npc, 1);
        chk("f_ir", id_ir, prog[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
